// File: rtl/gridcell_relax_unit.sv
// Grid cell with value history and a 4-neighbour weighted-relaxation stencil (IDLE -> SUM -> UPDATE).
// Optional saturating source term: define GRIDCELL_SOURCE_TERM_EN to add the SRC/SRC_EN inputs.
module gridcell_relax_unit #(
  parameter int WIDTH       = 8,
  parameter int HIST_DEPTH  = 2,
  parameter int OMEGA_SHIFT = 0,
  parameter int EPS         = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] VAL,
  input  logic             Fixed,
  input  logic             Step,
  input  logic [WIDTH-1:0] IN01,
  input  logic [WIDTH-1:0] IN0NEG1,
  input  logic [WIDTH-1:0] IN10,
  input  logic [WIDTH-1:0] INNEG10,
`ifdef GRIDCELL_SOURCE_TERM_EN
  input  logic [WIDTH-1:0] SRC,
  input  logic             SRC_EN,
`endif
  output logic [WIDTH-1:0] NEW_VAL,
  output logic [WIDTH-1:0] OLD_VAL,
  output logic             Busy,
  output logic             Done,
  output logic             Converged,
  output logic [WIDTH-1:0] Delta
);

  localparam int               SUM_W = WIDTH + 2;
  localparam logic [WIDTH-1:0] EPS_V = WIDTH'(EPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    UPDATE = 2'd2
  } relaxStateT;

  relaxStateT state;
  relaxStateT stateNext;

  logic [WIDTH-1:0] hist [HIST_DEPTH];

  logic [SUM_W-1:0] sum_p0;
  logic [SUM_W-1:0] sum_p1;
  logic             fixed_p1;
  logic [WIDTH-1:0] relaxed_p1;
  logic [WIDTH-1:0] newVal_p1;
  logic [WIDTH-1:0] deltaNext_p1;
  logic             commit_p1;
  logic             vld_p2;

  // cur + ((avg - cur) >>> OMEGA_SHIFT); the step is a fraction of the gap, so the result stays in range
  function automatic logic [WIDTH-1:0] relaxStep(input logic [SUM_W-1:0] sum,
                                                 input logic [WIDTH-1:0] cur);
    logic        [WIDTH-1:0] avg;
    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH:0]   scaled;
    logic signed [WIDTH:0]   res;
    avg    = WIDTH'(sum >> 2);
    diff   = $signed({1'b0, avg}) - $signed({1'b0, cur});
    scaled = diff >>> OMEGA_SHIFT;
    res    = $signed({1'b0, cur}) + scaled;
    return res[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] absDiff(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

`ifdef GRIDCELL_SOURCE_TERM_EN
  logic [WIDTH-1:0] src_p1;
  logic             srcEn_p1;

  function automatic logic [WIDTH-1:0] satAdd(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Load aborts any iteration and takes priority over Step
  always_comb begin
    stateNext = state;
    if (Load) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (Step) stateNext = SUM;
        SUM:     stateNext = UPDATE;
        UPDATE:  stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy = (state == SUM) || (state == UPDATE);
  end

  // ---- p0 -> p1: neighbour sum and per-iteration controls frozen at the SUM edge ----
  always_comb begin
    sum_p0 = SUM_W'(IN01) + SUM_W'(IN0NEG1) + SUM_W'(IN10) + SUM_W'(INNEG10);
  end

  always_ff @(posedge Clk) begin
    if (state == SUM) begin
      sum_p1   <= sum_p0;
      fixed_p1 <= Fixed;
`ifdef GRIDCELL_SOURCE_TERM_EN
      src_p1   <= SRC;
      srcEn_p1 <= SRC_EN;
`endif
    end
  end

  // ---- p1 -> p2: relaxation result committed into the history ----
  always_comb begin
    relaxed_p1 = relaxStep(sum_p1, hist[0]);
`ifdef GRIDCELL_SOURCE_TERM_EN
    if (srcEn_p1) relaxed_p1 = satAdd(relaxed_p1, src_p1);
`endif
    newVal_p1    = fixed_p1 ? hist[0] : relaxed_p1;
    deltaNext_p1 = absDiff(newVal_p1, hist[0]);
    commit_p1    = (state == UPDATE) && !Load;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
      Delta     <= '0;
      Converged <= 1'b0;
      vld_p2    <= 1'b0;
    end else if (Load) begin
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= VAL;
      Delta     <= '0;
      Converged <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= commit_p1;
      if (commit_p1) begin
        for (int k = 1; k < HIST_DEPTH; k++) hist[k] <= hist[k-1];
        hist[0]   <= newVal_p1;
        Delta     <= deltaNext_p1;
        Converged <= (deltaNext_p1 <= EPS_V);
      end
    end
  end

  assign NEW_VAL = hist[0];
  assign OLD_VAL = hist[HIST_DEPTH-1];
  assign Done    = vld_p2;

endmodule

// File: tb/tb_gridcell_relax_unit.sv
// Scoreboard bench for gridcell_relax_unit: three instances (Jacobi, OMEGA_SHIFT=1, HIST_DEPTH=4).
module tb_gridcell_relax_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       load  [3];
  logic       fixed [3];
  logic       step  [3];
  logic [7:0] val   [3];
  logic [7:0] n01   [3];
  logic [7:0] n0m1  [3];
  logic [7:0] n10   [3];
  logic [7:0] nm10  [3];
  logic [7:0] newVal[3];
  logic [7:0] oldVal[3];
  logic [7:0] delta [3];
  logic       busy  [3];
  logic       done  [3];
  logic       conv  [3];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] nv;
    logic [7:0] ov;
    logic [7:0] dl;
    logic       cv;
  } expT;

  expT qA[$];
  expT qB[$];
  expT qC[$];

  gridcell_relax_unit #(.WIDTH(8), .HIST_DEPTH(2), .OMEGA_SHIFT(0), .EPS(1)) dutA (
    .Clk(clk), .Reset(rstN), .Load(load[0]), .VAL(val[0]), .Fixed(fixed[0]), .Step(step[0]),
    .IN01(n01[0]), .IN0NEG1(n0m1[0]), .IN10(n10[0]), .INNEG10(nm10[0]),
`ifdef GRIDCELL_SOURCE_TERM_EN
    .SRC(8'd0), .SRC_EN(1'b0),
`endif
    .NEW_VAL(newVal[0]), .OLD_VAL(oldVal[0]), .Busy(busy[0]), .Done(done[0]),
    .Converged(conv[0]), .Delta(delta[0])
  );

  gridcell_relax_unit #(.WIDTH(8), .HIST_DEPTH(2), .OMEGA_SHIFT(1), .EPS(1)) dutB (
    .Clk(clk), .Reset(rstN), .Load(load[1]), .VAL(val[1]), .Fixed(fixed[1]), .Step(step[1]),
    .IN01(n01[1]), .IN0NEG1(n0m1[1]), .IN10(n10[1]), .INNEG10(nm10[1]),
`ifdef GRIDCELL_SOURCE_TERM_EN
    .SRC(8'd0), .SRC_EN(1'b0),
`endif
    .NEW_VAL(newVal[1]), .OLD_VAL(oldVal[1]), .Busy(busy[1]), .Done(done[1]),
    .Converged(conv[1]), .Delta(delta[1])
  );

  gridcell_relax_unit #(.WIDTH(8), .HIST_DEPTH(4), .OMEGA_SHIFT(0), .EPS(1)) dutC (
    .Clk(clk), .Reset(rstN), .Load(load[2]), .VAL(val[2]), .Fixed(fixed[2]), .Step(step[2]),
    .IN01(n01[2]), .IN0NEG1(n0m1[2]), .IN10(n10[2]), .INNEG10(nm10[2]),
`ifdef GRIDCELL_SOURCE_TERM_EN
    .SRC(8'd0), .SRC_EN(1'b0),
`endif
    .NEW_VAL(newVal[2]), .OLD_VAL(oldVal[2]), .Busy(busy[2]), .Done(done[2]),
    .Converged(conv[2]), .Delta(delta[2])
  );

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int c, input logic [7:0] nv, input logic [7:0] ov,
                      input logic [7:0] dl, input logic cv);
    expT e;
    e.cyc = c; e.nv = nv; e.ov = ov; e.dl = dl; e.cv = cv;
    case (d)
      0:       qA.push_back(e);
      1:       qB.push_back(e);
      default: qC.push_back(e);
    endcase
  endtask

  // Monitor: every Done pops one expected commit for that instance
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (done[d] === 1'b1) begin
        expT e;
        bit  have;
        have = 1'b0;
        case (d)
          0:       if (qA.size() > 0) begin e = qA.pop_front(); have = 1'b1; end
          1:       if (qB.size() > 0) begin e = qB.pop_front(); have = 1'b1; end
          default: if (qC.size() > 0) begin e = qC.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          checks++;
          failures++;
          $display("FAIL dut%0d_unexpected_done actual=1 required=0", d);
        end else begin
          chk($sformatf("dut%0d_done_cycle", d), cyc, e.cyc);
          chk($sformatf("dut%0d_new_val", d), newVal[d], e.nv);
          chk($sformatf("dut%0d_old_val", d), oldVal[d], e.ov);
          chk($sformatf("dut%0d_delta", d), delta[d], e.dl);
          chk($sformatf("dut%0d_converged", d), conv[d], e.cv);
          chk($sformatf("dut%0d_busy_with_done", d), busy[d], 0);
        end
      end
    end
  end

  task automatic doLoad(input int d, input logic [7:0] v);
    @(negedge clk);
    load[d] = 1'b1;
    val[d]  = v;
    @(negedge clk);
    load[d] = 1'b0;
  endtask

  task automatic setNbr(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e);
    n01[d] = a; n0m1[d] = b; n10[d] = c; nm10[d] = e;
  endtask

  task automatic doStep(input int d, input logic [7:0] nv, input logic [7:0] ov,
                        input logic [7:0] dl, input logic cv);
    @(negedge clk);
    step[d] = 1'b1;
    push(d, cyc + 3, nv, ov, dl, cv);
    @(negedge clk);
    step[d] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0;
    for (int d = 0; d < 3; d++) begin
      load[d] = 1'b0; fixed[d] = 1'b0; step[d] = 1'b0; val[d] = 8'd0;
      setNbr(d, 8'd0, 8'd0, 8'd0, 8'd0);
    end
    repeat (2) @(negedge clk);
    chk("reset_new_val", newVal[0], 0);
    chk("reset_old_val", oldVal[0], 0);
    chk("reset_busy", busy[0], 0);
    chk("reset_done", done[0], 0);
    chk("reset_converged", conv[0], 0);
    chk("reset_delta", delta[0], 0);
    rstN = 1'b1;

    // Pure Jacobi: cur 100, neighbours 10/20/30/40 -> avg 25
    doLoad(0, 8'd100);
    chk("load_new_val", newVal[0], 100);
    chk("load_old_val", oldVal[0], 100);
    setNbr(0, 8'd10, 8'd20, 8'd30, 8'd40);
    doStep(0, 8'd25, 8'd100, 8'd75, 1'b0);

    // Converged at rest, then a delta of exactly EPS
    doLoad(0, 8'd50);
    setNbr(0, 8'd50, 8'd50, 8'd50, 8'd50);
    doStep(0, 8'd50, 8'd50, 8'd0, 1'b1);
    n01[0] = 8'd54;
    doStep(0, 8'd51, 8'd50, 8'd1, 1'b1);

    // Boundary cell holds its value but still commits
    doLoad(0, 8'd100);
    fixed[0] = 1'b1;
    setNbr(0, 8'd0, 8'd0, 8'd0, 8'd0);
    doStep(0, 8'd100, 8'd100, 8'd0, 1'b1);
    fixed[0] = 1'b0;

    // Load and Step together: Load wins, no iteration starts
    @(negedge clk);
    load[0] = 1'b1; val[0] = 8'd40; step[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0; step[0] = 1'b0;
    chk("loadstep_busy", busy[0], 0);
    chk("loadstep_new_val", newVal[0], 40);
    repeat (3) @(negedge clk);

    // Load during SUM aborts the iteration
    doLoad(0, 8'd20);
    @(negedge clk);
    step[0] = 1'b1;
    @(negedge clk);
    step[0] = 1'b0;
    chk("abort_busy_in_sum", busy[0], 1);
    load[0] = 1'b1; val[0] = 8'd7;
    @(negedge clk);
    load[0] = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_new_val", newVal[0], 7);
    chk("abort_old_val", oldVal[0], 7);
    chk("abort_delta", delta[0], 0);
    chk("abort_converged", conv[0], 0);
    repeat (4) @(negedge clk);

    setNbr(0, 8'd40, 8'd40, 8'd40, 8'd40);
    doStep(0, 8'd40, 8'd7, 8'd33, 1'b0);

    // OMEGA_SHIFT=1: floor rounding in both directions
    doLoad(1, 8'd100);
    setNbr(1, 8'd10, 8'd20, 8'd30, 8'd40);
    doStep(1, 8'd62, 8'd100, 8'd38, 1'b0);
    setNbr(1, 8'd100, 8'd100, 8'd100, 8'd100);
    doStep(1, 8'd81, 8'd62, 8'd19, 1'b0);

    // HIST_DEPTH=4 with Step held high: one iteration every 3 cycles
    doLoad(2, 8'd0);
    setNbr(2, 8'd200, 8'd200, 8'd200, 8'd200);
    @(negedge clk);
    step[2] = 1'b1;
    push(2, cyc + 3, 8'd200, 8'd0, 8'd200, 1'b0);
    push(2, cyc + 6, 8'd200, 8'd0, 8'd0, 1'b1);
    push(2, cyc + 9, 8'd200, 8'd0, 8'd0, 1'b1);
    repeat (7) @(negedge clk);
    step[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("hist4_old_after3", oldVal[2], 0);

    // Step kept high through SUM/UPDATE is not queued
    @(negedge clk);
    step[2] = 1'b1;
    push(2, cyc + 3, 8'd200, 8'd200, 8'd0, 1'b1);
    repeat (3) @(negedge clk);
    step[2] = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset during UPDATE clears everything at once
    setNbr(0, 8'd200, 8'd200, 8'd200, 8'd200);
    @(negedge clk);
    step[0] = 1'b1;
    @(negedge clk);
    step[0] = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy[0], 1);
    chk("pre_reset_delta", delta[0], 33);
    #1 rstN = 1'b0;
    #1;
    chk("midreset_new_val", newVal[0], 0);
    chk("midreset_old_val", oldVal[0], 0);
    chk("midreset_delta", delta[0], 0);
    chk("midreset_converged", conv[0], 0);
    chk("midreset_busy", busy[0], 0);
    chk("midreset_done", done[0], 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    chk("pending_a", qA.size(), 0);
    chk("pending_b", qB.size(), 0);
    chk("pending_c", qC.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gridcell_relax_unit.md
Name: gridcell_relax_unit

Overview:
- Parametrised next-generation grid cell for the physics accelerator: per-cell value history plus a 4-neighbour stencil ALU.
- Adds a weighted relaxation factor, boundary (fixed) cells, a start/done handshake and convergence detection.
- One instance per grid point; neighbour buses come from adjacent cells' NEW_VAL outputs; Step is broadcast by the array sequencer.

Parameters:
- WIDTH, 8, unsigned cell value width (>=4)
- HIST_DEPTH, 2, stored generations (>=2); entry 0 newest
- OMEGA_SHIFT, 0, relaxation step = (avg-cur) >>> OMEGA_SHIFT (0..3; 0 = pure Jacobi)
- EPS, 1, convergence threshold on |new-prev|

Ports:
- Clk  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Load  in  1  preload all history entries with VAL
- VAL  in  WIDTH  preload value
- Fixed  in  1  boundary cell; value never changes on commit
- Step  in  1  request one relaxation iteration
- IN01, IN0NEG1, IN10, INNEG10  in  WIDTH each  neighbour values
- NEW_VAL  out  WIDTH  history entry 0 (current value)
- OLD_VAL  out  WIDTH  history entry HIST_DEPTH-1
- Busy  out  1  high in SUM and UPDATE
- Done  out  1  one-cycle pulse on commit
- Converged  out  1  last commit had delta <= EPS
- Delta  out  WIDTH  |new-prev| of last commit

Behaviour:
- Reset low: all history entries = 0, FSM = IDLE; Busy, Done, Converged = 0; Delta = 0. Takes effect immediately, including mid-iteration; no commit occurs.
- FSM IDLE -> SUM -> UPDATE -> IDLE.
  - IDLE: Step=1 at an edge -> SUM.
  - SUM: neighbours sampled, sum registered in WIDTH+2 bits. Neighbour changes after this edge have no effect.
  - UPDATE: commit on the next edge -> IDLE; Done=1 for the following cycle.
  - Latency: Step accepted at edge t; sum registered at t+1; NEW_VAL/Delta/Converged updated and Done high after edge t+2.
- Arithmetic:
  - avg = sum >> 2 (truncating).
  - diff = avg - cur, signed, WIDTH+1 bits.
  - new = cur + (diff >>> OMEGA_SHIFT), arithmetic shift, floor rounding.
  - Result is always within [0, 2^WIDTH-1]; no saturation needed.
- Fixed=1, sampled at the SUM edge: new = cur. Commit still shifts history and pulses Done; Delta = 0.
- Commit: history shifts toward the higher index (entry k <- entry k-1, entry 0 <- new). Delta = |new - cur|; Converged = (Delta <= EPS).
- Load=1 at any state: all entries <- VAL, FSM -> IDLE, Converged = 0, Delta = 0, no Done. An in-flight iteration is aborted.
- Load and Step in the same cycle: Load wins; Step is dropped.
- Step while Busy is ignored; it is not queued.
- Step held high continuously: a new iteration starts each time IDLE is re-entered, one iteration per 3 cycles.
- Done never coincides with Busy=1 in the same cycle.

Optional Feature:
- Macro GRIDCELL_SOURCE_TERM_EN.
- Defined:
  - Adds input SRC (WIDTH) and input SRC_EN (1), both sampled at the SUM edge.
  - When SRC_EN=1, new = min(relaxed + SRC, 2^WIDTH-1), saturating.
  - Fixed overrides the source term.
  - Delta and Converged use the final value.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Config WIDTH=8, HIST_DEPTH=2, OMEGA_SHIFT=0: Load VAL=100; neighbours 10/20/30/40; Step -> Done 3 cycles after Step, NEW_VAL=25, OLD_VAL=100, Delta=75, Converged=0.
- OMEGA_SHIFT=1, same stimulus -> NEW_VAL=62 (100 + floor(-75/2) = 100 - 38), Delta=38.
- All neighbours 50, cur 50, Step -> NEW_VAL=50, Delta=0, Converged=1. Then one neighbour to 54, Step -> avg 51, Delta=1, Converged=1 (EPS=1).
- Fixed=1, cur 100, neighbours 0 -> NEW_VAL=100, OLD_VAL=100, Delta=0, Done pulses.
- Step, then Load VAL=7 in the SUM cycle -> no Done, NEW_VAL=OLD_VAL=7, Busy=0. Separately, Reset low during UPDATE -> all outputs 0 immediately.
- HIST_DEPTH=4: Load 0, neighbours 200, three Steps -> NEW_VAL=200, OLD_VAL=0 after commit 3 (0 shifted out at commit 4). Step during Busy produces no extra Done.
